wb_bus_arbiter: RTL and testbench

Two-master, one-slave Wishbone classic arbiter that lets the pipeline's instruction-fetch master (IF) and data-memory master (MEM stage, `id_wb_*` on the CPU top) share a single Wishbone slave bus toward the SRAM controller. It sits between `cpu_master` and the memory subsystem. It holds a grant for the full duration of one transaction. It arbitrates between simultaneous requests by round-robin or by fixed data priority.

---
 rtl/wb_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_wb_bus_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_arbiter.sv
// Two-master / one-slave Wishbone classic arbiter (IF fetch vs. data port).
// A grant is held for one whole transaction, with an IDLE cycle between grants.
module wb_bus_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DATA_PRIORITY = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_wb_cyc_i,
  input  logic                    if_wb_stb_i,
  input  logic                    if_wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   if_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   if_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] if_wb_sel_i,
  output logic                    if_wb_ack_o,
  output logic [DATA_WIDTH-1:0]   if_wb_dat_o,
  input  logic                    id_wb_cyc_i,
  input  logic                    id_wb_stb_i,
  input  logic                    id_wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   id_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   id_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] id_wb_sel_i,
  output logic                    id_wb_ack_o,
  output logic [DATA_WIDTH-1:0]   id_wb_dat_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic                    wb_ack_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [1:0]              grant_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_GNT_IF = 2'b01,
    S_GNT_ID = 2'b10
  } state_t;

  state_t r_state;
  logic   r_last;

  logic w_if_req;
  logic w_id_req;
  logic w_gnt_if;
  logic w_gnt_id;

  assign w_if_req = if_wb_cyc_i & if_wb_stb_i;
  assign w_id_req = id_wb_cyc_i & id_wb_stb_i;
  assign w_gnt_if = (r_state == S_GNT_IF);
  assign w_gnt_id = (r_state == S_GNT_ID);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_last  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_if_req && w_id_req) begin
            // r_last=0 means IF went last, so the data port is next
            if (DATA_PRIORITY != 0 || !r_last)
              r_state <= S_GNT_ID;
            else
              r_state <= S_GNT_IF;
          end else if (w_if_req) begin
            r_state <= S_GNT_IF;
          end else if (w_id_req) begin
            r_state <= S_GNT_ID;
          end
        end
        S_GNT_IF: begin
          if (wb_ack_i) begin
            r_state <= S_IDLE;
            r_last  <= 1'b0;
          end else if (!if_wb_cyc_i) begin
            r_state <= S_IDLE;
          end
        end
        S_GNT_ID: begin
          if (wb_ack_i) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
          end else if (!id_wb_cyc_i) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_we_o     = 1'b0;
    wb_adr_o    = '0;
    wb_dat_o    = '0;
    wb_sel_o    = '0;
    if_wb_ack_o = 1'b0;
    id_wb_ack_o = 1'b0;
    unique case (1'b1)
      w_gnt_if: begin
        wb_cyc_o    = if_wb_cyc_i;
        wb_stb_o    = if_wb_stb_i;
        wb_we_o     = if_wb_we_i;
        wb_adr_o    = if_wb_adr_i;
        wb_dat_o    = if_wb_dat_i;
        wb_sel_o    = if_wb_sel_i;
        if_wb_ack_o = wb_ack_i;
      end
      w_gnt_id: begin
        wb_cyc_o    = id_wb_cyc_i;
        wb_stb_o    = id_wb_stb_i;
        wb_we_o     = id_wb_we_i;
        wb_adr_o    = id_wb_adr_i;
        wb_dat_o    = id_wb_dat_i;
        wb_sel_o    = id_wb_sel_i;
        id_wb_ack_o = wb_ack_i;
      end
      default: ;
    endcase
  end

  assign if_wb_dat_o = wb_dat_i;
  assign id_wb_dat_o = wb_dat_i;
  assign grant_o     = {w_gnt_id, w_gnt_if};

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Randomized bench for wb_bus_arbiter: round-robin and data-priority
// instances share stimulus and are checked against a transaction model.
module tb_wb_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW/8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          if_cyc = 0, if_stb = 0, if_we = 0;
  logic [AW-1:0] if_adr = '0;
  logic [DW-1:0] if_dat = '0;
  logic [SW-1:0] if_sel = '0;
  logic          id_cyc = 0, id_stb = 0, id_we = 0;
  logic [AW-1:0] id_adr = '0;
  logic [DW-1:0] id_dat = '0;
  logic [SW-1:0] id_sel = '0;
  logic          s_ack = 0;
  logic [DW-1:0] s_dat = '0;

  logic          o_cyc[2], o_stb[2], o_we[2];
  logic [AW-1:0] o_adr[2];
  logic [DW-1:0] o_dat[2];
  logic [SW-1:0] o_sel[2];
  logic          o_ifack[2], o_idack[2];
  logic [DW-1:0] o_ifdat[2], o_iddat[2];
  logic [1:0]    o_gnt[2];

  wb_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_PRIORITY(0)) u_rr (
    .clk(clk), .reset(reset),
    .if_wb_cyc_i(if_cyc), .if_wb_stb_i(if_stb), .if_wb_we_i(if_we),
    .if_wb_adr_i(if_adr), .if_wb_dat_i(if_dat), .if_wb_sel_i(if_sel),
    .if_wb_ack_o(o_ifack[0]), .if_wb_dat_o(o_ifdat[0]),
    .id_wb_cyc_i(id_cyc), .id_wb_stb_i(id_stb), .id_wb_we_i(id_we),
    .id_wb_adr_i(id_adr), .id_wb_dat_i(id_dat), .id_wb_sel_i(id_sel),
    .id_wb_ack_o(o_idack[0]), .id_wb_dat_o(o_iddat[0]),
    .wb_cyc_o(o_cyc[0]), .wb_stb_o(o_stb[0]), .wb_we_o(o_we[0]),
    .wb_adr_o(o_adr[0]), .wb_dat_o(o_dat[0]), .wb_sel_o(o_sel[0]),
    .wb_ack_i(s_ack), .wb_dat_i(s_dat), .grant_o(o_gnt[0])
  );

  wb_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_PRIORITY(1)) u_dp (
    .clk(clk), .reset(reset),
    .if_wb_cyc_i(if_cyc), .if_wb_stb_i(if_stb), .if_wb_we_i(if_we),
    .if_wb_adr_i(if_adr), .if_wb_dat_i(if_dat), .if_wb_sel_i(if_sel),
    .if_wb_ack_o(o_ifack[1]), .if_wb_dat_o(o_ifdat[1]),
    .id_wb_cyc_i(id_cyc), .id_wb_stb_i(id_stb), .id_wb_we_i(id_we),
    .id_wb_adr_i(id_adr), .id_wb_dat_i(id_dat), .id_wb_sel_i(id_sel),
    .id_wb_ack_o(o_idack[1]), .id_wb_dat_o(o_iddat[1]),
    .wb_cyc_o(o_cyc[1]), .wb_stb_o(o_stb[1]), .wb_we_o(o_we[1]),
    .wb_adr_o(o_adr[1]), .wb_dat_o(o_dat[1]), .wb_sel_o(o_sel[1]),
    .wb_ack_i(s_ack), .wb_dat_i(s_dat), .grant_o(o_gnt[1])
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Model: owner 0 = nobody, 1 = IF, 2 = data; lst 0 = IF served last
  int owner[2];
  bit lst[2];

  task automatic mdl_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = 0;
      lst[k]   = 0;
    end
  endtask

  task automatic mdl_next(int k);
    bit ri = if_cyc & if_stb;
    bit rd = id_cyc & id_stb;
    int cur = owner[k];
    if (cur == 0) begin
      if (ri && rd)      owner[k] = (k == 1 || lst[k] == 0) ? 2 : 1;
      else if (ri)       owner[k] = 1;
      else if (rd)       owner[k] = 2;
    end else if (s_ack) begin
      owner[k] = 0;
      lst[k]   = (cur == 2);
    end else if (!(cur == 1 ? if_cyc : id_cyc)) begin
      owner[k] = 0;
    end
  endtask

  task automatic cmp_inst(int k);
    logic [70:0] eb;
    logic [70:0] gb;
    eb = '0;
    if (owner[k] == 1) eb = {if_cyc, if_stb, if_we, if_adr, if_dat, if_sel};
    if (owner[k] == 2) eb = {id_cyc, id_stb, id_we, id_adr, id_dat, id_sel};
    gb = {o_cyc[k], o_stb[k], o_we[k], o_adr[k], o_dat[k], o_sel[k]};
    check($sformatf("bus%0d", k), gb, eb);
    check($sformatf("ifack%0d", k), o_ifack[k], (owner[k] == 1) ? s_ack : 1'b0);
    check($sformatf("idack%0d", k), o_idack[k], (owner[k] == 2) ? s_ack : 1'b0);
    check($sformatf("grant%0d", k), o_gnt[k], owner[k][1:0]);
    check($sformatf("rdat%0d", k), {o_ifdat[k], o_iddat[k]}, {s_dat, s_dat});
  endtask

  task automatic probe();
    #3;
    cmp_inst(0);
    cmp_inst(1);
  endtask

  task automatic advance();
    mdl_next(0);
    mdl_next(1);
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    probe();
    advance();
  endtask

  task automatic idle_all();
    if_cyc = 0; if_stb = 0; if_we = 0; if_adr = '0; if_dat = '0; if_sel = '0;
    id_cyc = 0; id_stb = 0; id_we = 0; id_adr = '0; id_dat = '0; id_sel = '0;
    s_ack = 0; s_dat = '0;
  endtask

  logic [1:0] rr_exp [8] = '{2'b00, 2'b10, 2'b00, 2'b01,
                             2'b00, 2'b10, 2'b00, 2'b01};
  logic [1:0] prev_g;

  initial begin
    mdl_reset();
    @(posedge clk);
    #1;
    check("rst_cyc", o_cyc[0], 1'b0);
    check("rst_gnt", o_gnt[0], 2'b00);
    reset = 1'b0;

    // Single IF read, slave acks two cycles after the request
    if_cyc = 1; if_stb = 1; if_adr = 32'h8000_0000; if_sel = 4'hF;
    step();
    step();
    s_ack = 1; s_dat = 32'h0000_0013;
    probe();
    check("ifrd_ack", o_ifack[0], 1'b1);
    check("ifrd_dat", o_ifdat[0], 32'h13);
    check("ifrd_idack", o_idack[0], 1'b0);
    advance();
    if_cyc = 0; if_stb = 0; s_ack = 0;
    probe();
    check("ifrd_gnt_after", o_gnt[0], 2'b00);
    advance();

    // Continuous tie with immediate acks
    if_cyc = 1; if_stb = 1; id_cyc = 1; id_stb = 1; s_ack = 1;
    prev_g = 2'b00;
    for (int i = 0; i < 8; i++) begin
      probe();
      check($sformatf("rr_seq%0d", i), o_gnt[0], rr_exp[i]);
      if (o_gnt[0] != 2'b00) begin
        if (prev_g != 2'b00) check("rr_alt", o_gnt[0] != prev_g, 1'b1);
        prev_g = o_gnt[0];
      end
      check($sformatf("dp_seq%0d", i), o_gnt[1], (i % 2) ? 2'b10 : 2'b00);
      advance();
    end
    id_cyc = 0; id_stb = 0;
    step();
    step();
    idle_all();
    step();
    step();

    // Data write passthrough
    id_cyc = 1; id_stb = 1; id_we = 1; id_adr = 32'h8010_0000;
    id_dat = 32'hDEAD_BEEF; id_sel = 4'h1;
    step();
    probe();
    check("wr_bus", {o_cyc[0], o_we[0], o_adr[0], o_dat[0], o_sel[0]},
          {2'b11, 32'h8010_0000, 32'hDEAD_BEEF, 4'h1});
    advance();
    s_ack = 1;
    step();
    id_cyc = 0; id_stb = 0; s_ack = 0;
    probe();
    check("wr_idle_bus", {o_cyc[0], o_we[0], o_adr[0], o_dat[0], o_sel[0]}, '0);
    advance();
    idle_all();

    // IF abort leaves last as data, so the next tie goes to IF
    if_cyc = 1; if_stb = 1;
    step();
    step();
    if_cyc = 0; if_stb = 0;
    step();
    probe();
    check("abort_idle", o_gnt[0], 2'b00);
    advance();
    if_cyc = 1; if_stb = 1; id_cyc = 1; id_stb = 1;
    step();
    probe();
    check("abort_last", o_gnt[0], 2'b01);
    advance();
    idle_all();
    step();
    step();

    // Stray acks in IDLE are dropped
    s_ack = 1;
    for (int i = 0; i < 3; i++) begin
      probe();
      check("stray_ack", {o_ifack[0], o_idack[0], o_ifack[1], o_idack[1]}, 4'b0);
      advance();
    end
    idle_all();

    // Reset in the middle of a data grant
    id_cyc = 1; id_stb = 1;
    step();
    probe();
    check("pre_rst_cyc", o_cyc[0], 1'b1);
    advance();
    #2;
    reset = 1'b1;
    #1;
    mdl_reset();
    check("mid_rst_cyc", {o_cyc[0], o_cyc[1]}, 2'b00);
    check("mid_rst_gnt", {o_gnt[0], o_gnt[1]}, 4'b0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    if_cyc = 1; if_stb = 1;
    step();
    probe();
    check("post_rst_tie", o_gnt[0], 2'b10);
    advance();
    s_ack = 1;
    step();
    idle_all();
    step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if_cyc = ($urandom_range(0, 3) != 0);
      if_stb = if_cyc & ($urandom_range(0, 4) != 0);
      if_we  = $urandom_range(0, 1);
      if_adr = $urandom;
      if_dat = $urandom;
      if_sel = SW'($urandom);
      id_cyc = ($urandom_range(0, 2) != 0);
      id_stb = id_cyc & ($urandom_range(0, 4) != 0);
      id_we  = $urandom_range(0, 1);
      id_adr = $urandom;
      id_dat = $urandom;
      id_sel = SW'($urandom);
      s_ack  = ($urandom_range(0, 2) == 0);
      s_dat  = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
